chargen_ctrl: RTL and testbench

CHARGEN_CTRL -- requirements
Module: chargen_ctrl

---
 rtl/chargen_if.sv | 10 +
 rtl/chargen_ctrl.sv | 99 +++++++++
 tb/tb_chargen_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/chargen_if.sv
// FIFO write-port bundle between the character generator and a byte FIFO.
// The generator is the master: it drives data and the write strobe and samples the not-full flag.
interface chargen_if;
    logic [7:0] fifo_data;
    logic       n_wr;
    logic       n_full;

    modport master (output fifo_data, output n_wr, input n_full);
    modport slave  (input fifo_data, input n_wr, output n_full);
endinterface

// File: rtl/chargen_ctrl.sv
// Chargen-style rotating character source: LINE_LEN printable bytes then CR LF,
// each line starting one character later in the set than the previous one.
module chargen_ctrl #(
    parameter int unsigned LINE_LEN   = 72,
    parameter logic [7:0]  FIRST_CHAR = 8'h21,
    parameter int unsigned NUM_CHARS  = 95
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    chargen_if.master        fifo,
    output logic             busy,
    output logic [15:0]      line_cnt
);

    typedef enum logic [1:0] {IDLE, CHAR, CR, LF} state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_CHARS - 1);
    localparam logic [7:0] LAST_COL = 8'(LINE_LEN - 1);
    localparam logic [7:0] CR_CODE  = 8'h0D;
    localparam logic [7:0] LF_CODE  = 8'h0A;

    function automatic logic [7:0] idx_inc(input logic [7:0] idx);
        return (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cur_idx_q, cur_idx_d;
    logic [7:0]  line_start_q, line_start_d;
    logic [7:0]  column_q, column_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        accept;

    // Data depends on registered state only; n_full only gates the strobe.
    always_comb begin
        accept         = (state_q != IDLE) && fifo.n_full;
        fifo.n_wr      = ~accept;
        busy           = (state_q != IDLE);
        line_cnt       = line_cnt_q;
        fifo.fifo_data = 8'h00;
        unique case (state_q)
            CHAR:    fifo.fifo_data = FIRST_CHAR + cur_idx_q;
            CR:      fifo.fifo_data = CR_CODE;
            LF:      fifo.fifo_data = LF_CODE;
            default: fifo.fifo_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        line_start_d = line_start_q;
        column_d     = column_q;
        line_cnt_d   = line_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = CHAR;
            end
            CHAR: begin
                if (accept) begin
                    cur_idx_d = idx_inc(cur_idx_q);
                    column_d  = column_q + 8'd1;
                    if (column_q == LAST_COL) state_d = CR;
                end
            end
            CR: begin
                if (accept) state_d = LF;
            end
            LF: begin
                // en is only consulted here, so a line is never cut short.
                if (accept) begin
                    line_start_d = idx_inc(line_start_q);
                    cur_idx_d    = idx_inc(line_start_q);
                    column_d     = 8'd0;
                    line_cnt_d   = line_cnt_q + 16'd1;
                    state_d      = en ? CHAR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_idx_q    <= 8'd0;
            line_start_q <= 8'd0;
            column_q     <= 8'd0;
            line_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            line_start_q <= line_start_d;
            column_q     <= column_d;
            line_cnt_q   <= line_cnt_d;
        end
    end

endmodule

// File: tb/tb_chargen_ctrl.sv
// Bench for chargen_ctrl: a default instance and a small (LINE_LEN=4, NUM_CHARS=5) instance
// share stimulus and are both compared every cycle against a byte-stream reference model.
module tb_chargen_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, nf;
    logic busy0, busy1;
    logic [15:0] lc0, lc1;

    chargen_if bus0();
    chargen_if bus1();
    assign bus0.n_full = nf;
    assign bus1.n_full = nf;

    chargen_ctrl dut0 (.clk(clk), .rst(rst), .en(en), .fifo(bus0), .busy(busy0), .line_cnt(lc0));
    chargen_ctrl #(.LINE_LEN(4), .FIRST_CHAR(8'h21), .NUM_CHARS(5))
        dut1 (.clk(clk), .rst(rst), .en(en), .fifo(bus1), .busy(busy1), .line_cnt(lc1));

    logic [7:0]  o_data[2];
    logic        o_nwr[2];
    logic        o_busy[2];
    logic [15:0] o_lc[2];
    assign o_data[0] = bus0.fifo_data;  assign o_data[1] = bus1.fifo_data;
    assign o_nwr[0]  = bus0.n_wr;       assign o_nwr[1]  = bus1.n_wr;
    assign o_busy[0] = busy0;           assign o_busy[1] = busy1;
    assign o_lc[0]   = lc0;             assign o_lc[1]   = lc1;

    int checks = 0;
    int errors = 0;

    // Reference model: line L (since reset) byte p is FIRST + (L+p) mod N, then CR, LF.
    bit          m_act[2];
    int          m_L[2];
    int          m_p[2];
    logic [15:0] m_lc[2];
    int          LL[2] = '{72, 4};
    int          NC[2] = '{95, 5};
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];

    typedef struct {
        bit r; bit e; bit n;
        logic [7:0] d; bit nwr; bit busy;
    } vec_t;
    vec_t tab[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        if (!m_act[i]) return 8'h00;
        if (m_p[i] < LL[i]) return 8'(8'h21 + ((m_L[i] + m_p[i]) % NC[i]));
        if (m_p[i] == LL[i]) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic void model_step(input int i, input bit e, input bit n, input bit r);
        if (r) begin
            m_act[i] = 0; m_L[i] = 0; m_p[i] = 0; m_lc[i] = 16'h0000;
        end else if (m_act[i]) begin
            if (n) begin
                m_p[i]++;
                if (m_p[i] == LL[i] + 2) begin
                    m_p[i] = 0; m_L[i]++; m_lc[i] = m_lc[i] + 16'd1; m_act[i] = e;
                end
            end
        end else if (e) begin
            m_act[i] = 1; m_p[i] = 0;
        end
    endfunction

    // Enter at posedge+1, drive, compare on the falling edge, leave at the next posedge+1.
    task automatic cyc(input bit e, input bit n, input bit r, input bit use_v, input vec_t v);
        en = e; nf = n; rst = r;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("data%0d", i), {24'h0, o_data[i]}, {24'h0, exp_byte(i)});
            chk($sformatf("n_wr%0d", i), {31'h0, o_nwr[i]}, {31'h0, !(m_act[i] && n)});
            chk($sformatf("busy%0d", i), {31'h0, o_busy[i]}, {31'h0, m_act[i]});
            chk($sformatf("line_cnt%0d", i), {16'h0, o_lc[i]}, {16'h0, m_lc[i]});
        end
        if (use_v) begin
            chk("vec_data", {24'h0, o_data[0]}, {24'h0, v.d});
            chk("vec_n_wr", {31'h0, o_nwr[0]}, {31'h0, v.nwr});
            chk("vec_busy", {31'h0, o_busy[0]}, {31'h0, v.busy});
        end
        if (o_nwr[0] == 1'b0) q0.push_back(o_data[0]);
        if (o_nwr[1] == 1'b0) q1.push_back(o_data[1]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_step(i, e, n, r);
    endtask

    task automatic step(input bit e, input bit n, input bit r);
        vec_t z;
        z = '{r: 0, e: 0, n: 0, d: 8'h00, nwr: 0, busy: 0};
        cyc(e, n, r, 1'b0, z);
    endtask

    initial begin
        int cnt;
        //            r  e  n  data   n_wr busy
        tab[0]  = '{0, 0, 1, 8'h00, 1, 0};
        tab[1]  = '{0, 1, 1, 8'h00, 1, 0};
        tab[2]  = '{0, 0, 1, 8'h21, 0, 1};
        tab[3]  = '{0, 0, 0, 8'h22, 1, 1};
        tab[4]  = '{0, 0, 0, 8'h22, 1, 1};
        tab[5]  = '{0, 0, 1, 8'h22, 0, 1};
        tab[6]  = '{1, 1, 1, 8'h23, 0, 1};
        tab[7]  = '{0, 0, 1, 8'h00, 1, 0};
        tab[8]  = '{0, 1, 0, 8'h00, 1, 0};
        tab[9]  = '{0, 0, 0, 8'h21, 1, 1};
        tab[10] = '{1, 0, 0, 8'h21, 1, 1};
        tab[11] = '{0, 0, 1, 8'h00, 1, 0};

        rst = 1'b1; en = 1'b0; nf = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_step(i, 0, 1, 1);

        for (int k = 0; k < 12; k++) cyc(tab[k].e, tab[k].n, tab[k].r, 1'b1, tab[k]);

        // Free-running from reset: default line 0 then start of line 1; small instance wraps.
        step(0, 1, 1);
        q0.delete(); q1.delete();
        for (int k = 0; k < 149; k++) step(1, 1, 0);
        chk("run_line_cnt", {16'h0, lc0}, 32'd2);
        chk("run_q0_size", {31'h0, q0.size() >= 75}, 32'd1);
        chk("run_first", {24'h0, q0[0]}, 32'h21);
        chk("run_last_char", {24'h0, q0[71]}, 32'h68);
        chk("run_cr", {24'h0, q0[72]}, 32'h0D);
        chk("run_lf", {24'h0, q0[73]}, 32'h0A);
        chk("run_line1_start", {24'h0, q0[74]}, 32'h22);
        for (int k = 0; k < 6; k++)
            chk($sformatf("small_line%0d_start", k), {24'h0, q1[6*k]}, 32'h21 + (k % 5));
        chk("small_inline_wrap", {24'h0, q1[15]}, 32'h21);
        chk("small_cr", {24'h0, q1[4]}, 32'h0D);

        // Stalls mid-line and during CR.
        step(0, 1, 1);
        cnt = 0;
        while (!(m_act[0] && m_p[0] == 10) && cnt < 300) begin step(1, 1, 0); cnt++; end
        chk("stall_col10_reached", {31'h0, m_p[0] == 10}, 32'd1);
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        cnt = 0;
        while (m_p[0] != 72 && cnt < 300) begin step(1, 1, 0); cnt++; end
        chk("stall_cr_reached", {31'h0, m_p[0] == 72}, 32'd1);
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        for (int k = 0; k < 80; k++) step(1, 1, 0);

        // en dropped at column 10: line finishes, then resumes at the next line start.
        step(0, 1, 1);
        cnt = 0;
        while (!(m_act[0] && m_p[0] == 10) && cnt < 300) begin step(1, 1, 0); cnt++; end
        chk("drop_col10_reached", {31'h0, m_p[0] == 10}, 32'd1);
        cnt = 0;
        while (m_act[0] && cnt < 300) begin step(0, 1, 0); cnt++; end
        chk("drop_idle_busy", {31'h0, busy0}, 32'd0);
        chk("drop_line_cnt", {16'h0, lc0}, 32'd1);
        step(1, 1, 0);
        chk("resume_busy", {31'h0, busy0}, 32'd1);
        chk("resume_byte", {24'h0, bus0.fifo_data}, 32'h22);

        // Reset while presenting CR of the second line.
        step(0, 1, 1);
        cnt = 0;
        while (!(m_L[0] == 1 && m_p[0] == 72) && cnt < 400) begin step(1, 1, 0); cnt++; end
        chk("rstcr_reached", {31'h0, m_p[0] == 72}, 32'd1);
        step(1, 1, 1);
        chk("rstcr_n_wr", {31'h0, bus0.n_wr}, 32'd1);
        chk("rstcr_busy", {31'h0, busy0}, 32'd0);
        chk("rstcr_line_cnt", {16'h0, lc0}, 32'd0);
        step(1, 1, 0);
        chk("rstcr_restart", {24'h0, bus0.fifo_data}, 32'h21);

        // line_cnt wrap from 16'hFFFF.
        step(0, 1, 1);
        step(0, 1, 0);
        force dut0.line_cnt_q = 16'hFFFF;
        m_lc[0] = 16'hFFFF;
        step(0, 1, 0);
        release dut0.line_cnt_q;
        step(0, 1, 0);
        cnt = 0;
        while (m_L[0] != 1 && cnt < 300) begin step(1, 1, 0); cnt++; end
        chk("wrap_line_cnt", {16'h0, lc0}, 32'd0);

        // Randomized traffic with occasional resets.
        step(0, 1, 1);
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
